fetch_ctrl: RTL and testbench

- Instruction fetch sequencer for the 16-bit MIPS-lab core.
- Owns the PC and drives the combinational-read Instruction_Mem address port every cycle.
- Buffers each fetched {pc, instruction} pair in a small FIFO and presents it to decode with a valid/ready handshake.
- Handles branch/jump redirects (flush plus PC reload) and stops fetching on a HALT encoding.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and fetch-buffer entry type for the fetch sequencer.
package fetch_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;

   localparam logic [3:0] HALT_OPC = 4'hF;

   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t ST_IDLE = 2'd0;
   localparam fetch_state_t ST_RUN  = 2'd1;
   localparam fetch_state_t ST_HALT = 2'd2;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Instructions are halfword aligned, so the low address bit is forced to zero.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
      return addr & ~{{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {pc, instr} entries between fetch and decode.
// When empty, rd_data keeps showing the last head so decode never sees X.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_data,
   output fetch_entry_t rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  hold_q, hold_d;
   fetch_entry_t  head;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_data = empty ? hold_q : head;

   // Flush dominates: it also discards an entry being popped this cycle.
   assign push_ok = push & ~flush & (~full | pop);
   assign pop_ok  = pop & ~flush & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      hold_d   = rd_data;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hold_q   <= hold_d;
         if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, redirect/halt FSM and decode-side fetch buffer.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush performance counters.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; redirect only reloads the PC
//   ST_RUN  | fetching one instruction per cycle while the buffer has room
//   ST_HALT | HALT word fetched; buffer drains, only rst leaves this state
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [3:0]  HALT_OPC   = fetch_pkg::HALT_OPC
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic [fetch_pkg::ADDR_W-1:0]  im_addr,
   input  logic [fetch_pkg::INSTR_W-1:0] im_instr,
   input  logic                          redirect_valid,
   input  logic [fetch_pkg::ADDR_W-1:0]  redirect_target,
   output logic                          dec_valid,
   input  logic                          dec_ready,
   output logic [fetch_pkg::INSTR_W-1:0] dec_instr,
   output logic [fetch_pkg::ADDR_W-1:0]  dec_pc,
   output logic                          halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]                   perf_stall_cnt,
   output logic [15:0]                   perf_flush_cnt
`endif
);

   import fetch_pkg::*;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              in_run;
   logic              push;
   logic              pop;
   logic              flush;
   logic              full;
   logic              empty;
   logic              is_halt;
   fetch_entry_t      wr_entry;
   fetch_entry_t      head;

   assign in_run    = (state_q == ST_RUN);
   assign dec_valid = ~empty;
   assign pop       = dec_valid & dec_ready;
   assign flush     = in_run & redirect_valid;
   assign push      = in_run & ~redirect_valid & (~full | pop);
   assign is_halt   = (im_instr[INSTR_W-1 -: 4] == HALT_OPC);
   assign wr_entry  = '{pc: pc_q, instr: im_instr};

   assign im_addr   = pc_q;
   assign dec_instr = head.instr;
   assign dec_pc    = head.pc;
   assign halted    = (state_q == ST_HALT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid) pc_d = align_pc(redirect_target);
            if (start)          state_d = ST_RUN;
         end
         ST_RUN: begin
            // A redirect in the same cycle as a HALT fetch discards the HALT word.
            if (redirect_valid) begin
               pc_d = align_pc(redirect_target);
            end else if (push) begin
               pc_d = pc_q + ADDR_W'(2);
               if (is_halt) state_d = ST_HALT;
            end
         end
         ST_HALT: ;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (in_run && !redirect_valid && full && !pop && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush && !empty && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, redirect_valid, dec_ready;
   logic [15:0] redirect_target, im_addr, im_instr, dec_instr, dec_pc;
   logic        dec_valid, halted;
   logic        halt_en;
   logic [15:0] halt_addr;

   logic        rst1, start1, dec_ready1, dec_valid1, halted1;
   logic [15:0] im_addr1, im_instr1, dec_instr1, dec_pc1;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt1, perf_flush_cnt1;
`endif

   // Behavioural instruction memory: word at addr reads addr>>1 unless HALT is planted.
   assign im_instr  = (halt_en && im_addr == halt_addr) ? 16'hF000 : {1'b0, im_addr[15:1]};
   assign im_instr1 = {1'b0, im_addr1[15:1]};

   fetch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .im_addr         (im_addr),
      .im_instr        (im_instr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_instr       (dec_instr),
      .dec_pc          (dec_pc),
      .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   fetch_ctrl #(.RESET_PC(16'hFFFC)) dut_wrap (
      .clk             (clk),
      .rst             (rst1),
      .start           (start1),
      .im_addr         (im_addr1),
      .im_instr        (im_instr1),
      .redirect_valid  (1'b0),
      .redirect_target (16'h0000),
      .dec_valid       (dec_valid1),
      .dec_ready       (dec_ready1),
      .dec_instr       (dec_instr1),
      .dec_pc          (dec_pc1),
      .halted          (halted1)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt1),
      .perf_flush_cnt  (perf_flush_cnt1)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: an ordered list of buffered fetches plus a PC and two mode flags.
   typedef struct {
      logic [15:0] pc;
      logic [15:0] ins;
   } ent_t;

   localparam int DEPTH = 2;

   ent_t        m_q[$];
   logic [15:0] m_pc, m_last_pc, m_last_ins, m_stall, m_flush;
   bit          m_fetching, m_halted;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (halt_en && a == halt_addr) return 16'hF000;
      return a >> 1;
   endfunction

   task automatic model_step(input logic r, s, rv, input logic [15:0] rt, input logic rd);
      bit was_fetching;
      bit pop;
      ent_t e;
      was_fetching = m_fetching;
      pop = (m_q.size() != 0) && rd;
      if (r) begin
         m_q.delete();
         m_pc = 16'h0000;
         m_fetching = 0;
         m_halted = 0;
         m_last_pc = 0;
         m_last_ins = 0;
         m_stall = 0;
         m_flush = 0;
         return;
      end
      if (was_fetching && rv) begin
         if (m_q.size() > 0 && m_flush != 16'hFFFF) m_flush++;
         m_q.delete();
         m_pc = rt & 16'hFFFE;
         return;
      end
      if (!was_fetching && !m_halted) begin
         if (rv) m_pc = rt & 16'hFFFE;
         if (s)  m_fetching = 1;
      end
      if (pop) void'(m_q.pop_front());
      if (was_fetching) begin
         if (m_q.size() < DEPTH) begin
            e.pc  = m_pc;
            e.ins = mem_word(m_pc);
            m_q.push_back(e);
            if (e.ins[15:12] == 4'hF) begin
               m_fetching = 0;
               m_halted = 1;
            end
            m_pc = m_pc + 16'd2;
         end else if (m_stall != 16'hFFFF) begin
            m_stall++;
         end
      end
   endtask

   // Called at a falling edge: compare against the model, drive inputs, advance one cycle.
   task automatic tick(input logic r, s, rv, input logic [15:0] rt, input logic rd);
      if (m_q.size() != 0) begin
         m_last_pc  = m_q[0].pc;
         m_last_ins = m_q[0].ins;
      end
      chk("im_addr", im_addr, m_pc);
      chk("dec_valid", dec_valid, 32'(m_q.size() != 0));
      chk("dec_pc", dec_pc, m_last_pc);
      chk("dec_instr", dec_instr, m_last_ins);
      chk("halted", halted, 32'(m_halted));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall", perf_stall_cnt, m_stall);
      chk("perf_flush", perf_flush_cnt, m_flush);
`endif
      rst = r;
      start = s;
      redirect_valid = rv;
      redirect_target = rt;
      dec_ready = rd;
      model_step(r, s, rv, rt, rd);
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic rd);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0000, rd);
   endtask

   initial begin
      halt_en = 1'b0;
      halt_addr = 16'h0010;
      rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_target = '0; dec_ready = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; dec_ready1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);

      chk("rst_im_addr", im_addr, 16'h0000);
      chk("rst_dec_valid", dec_valid, 1'b0);
      chk("rst_dec_pc", dec_pc, 16'h0000);
      chk("rst_dec_instr", dec_instr, 16'h0000);
      chk("rst_halted", halted, 1'b0);

      // Test 1: start latency and sequential stream
      tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      chk("t1_bubble", dec_valid, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("t1_valid", dec_valid, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk("t1_pc", dec_pc, 16'(2 * k));
         chk("t1_instr", dec_instr, 16'(k));
         tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      end

      // Test 2: backpressure fills the buffer, then drains in order
      tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      run(6, 1'b0);
      chk("t2_im_addr_hold", im_addr, 16'h0004);
      chk("t2_head_pc", dec_pc, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         chk("t2_seq_pc", dec_pc, 16'(2 * k));
         tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      end

      // Test 3: redirect flushes a full buffer; odd target is aligned
      run(3, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 16'h0061, 1'b1);
      chk("t3_flushed", dec_valid, 1'b0);
      chk("t3_im_addr", im_addr, 16'h0060);
      tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("t3_valid", dec_valid, 1'b1);
      chk("t3_pc", dec_pc, 16'h0060);
      chk("t3_instr", dec_instr, 16'd48);
      tick(1'b0, 1'b0, 1'b1, 16'h0050, 1'b1);
      run(1, 1'b1);
      chk("t3b_pc", dec_pc, 16'h0050);
      chk("t3b_instr", dec_instr, 16'd40);

      // Test 4: HALT word at 0x0010 is delivered, then fetch stops
      halt_en = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      run(9, 1'b1);
      chk("t4_halted", halted, 1'b1);
      chk("t4_halt_pc", dec_pc, 16'h0010);
      chk("t4_halt_instr", dec_instr, 16'hF000);
      chk("t4_im_addr", im_addr, 16'h0012);
      tick(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
      tick(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
      chk("t4_still_halted", halted, 1'b1);
      chk("t4_im_addr_hold", im_addr, 16'h0012);
      chk("t4_drained", dec_valid, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("t4_rst_halted", halted, 1'b0);
      chk("t4_rst_im_addr", im_addr, 16'h0000);

      // Test 5: redirect while the HALT word is on the memory bus wins
      tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      run(8, 1'b1);
      chk("t5_at_halt", im_addr, 16'h0010);
      tick(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1);
      run(1, 1'b1);
      chk("t5_pc", dec_pc, 16'h0040);
      chk("t5_instr", dec_instr, 16'h0020);
      chk("t5_not_halted", halted, 1'b0);
      run(6, 1'b1);
      chk("t5_not_halted_later", halted, 1'b0);

      // Randomized traffic against the model
      for (int ep = 0; ep < 12; ep++) begin
         halt_en = $urandom_range(0, 1);
         halt_addr = 16'($urandom_range(4, 60) * 2);
         tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
         tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
         for (int i = 0; i < 80; i++) begin
            tick($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 10,
                 16'($urandom_range(0, 127)),
                 $urandom_range(0, 99) < 70);
         end
      end
      tick(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

      // Test 6: PC wrap from RESET_PC=0xFFFC, then reset mid-stream
      chk("t6_rst_im_addr", im_addr1, 16'hFFFC);
      chk("t6_rst_valid", dec_valid1, 1'b0);
      rst1 = 1'b0; start1 = 1'b1; dec_ready1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("t6_bubble", dec_valid1, 1'b0);
      @(negedge clk);
      chk("t6_pc0", dec_pc1, 16'hFFFC);
      chk("t6_instr0", dec_instr1, 16'h7FFE);
      @(negedge clk);
      chk("t6_pc1", dec_pc1, 16'hFFFE);
      chk("t6_instr1", dec_instr1, 16'h7FFF);
      @(negedge clk);
      chk("t6_pc2", dec_pc1, 16'h0000);
      chk("t6_instr2", dec_instr1, 16'h0000);
      chk("t6_valid_before_rst", dec_valid1, 1'b1);
      rst1 = 1'b1;
      @(negedge clk);
      chk("t6_rst_mid_valid", dec_valid1, 1'b0);
      chk("t6_rst_mid_pc", im_addr1, 16'hFFFC);
      rst1 = 1'b0;
      @(negedge clk);
      chk("t6_idle_after_rst", dec_valid1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
